cell_plotter: RTL and testbench

- Parametrised pixel-sweep engine between game control logic and the 160x120 vga_adapter plot interface.
- Accepts one "draw cell" request (grid column, row, colour) through a valid/ready handshake.
- Rasterises the cell into CELL_W x CELL_H pixels at a fixed board origin, one pixel per clock.
- Adds an optional border colour and screen clipping.

---
 rtl/cell_plotter.sv | 226 ++++++++++++++++++++++
 tb/tb_cell_plotter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cell_plotter.sv
// Cell rasteriser: sweeps one grid cell (or the whole screen when CELL_PLOTTER_CLEAR_EN
// is defined) into the vga_adapter plot port, one pixel per clock.
//   state | meaning
//   IDLE  | waiting for a request, req_ready high
//   DRAW  | one pixel per cycle
//   DONE  | one-cycle done pulse
module cell_plotter #(
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int COLOUR_W = 6,
  parameter int COL_W    = 4,
  parameter int ROW_W    = 5,
  parameter int CELL_W   = 4,
  parameter int CELL_H   = 4,
  parameter int ORIGIN_X = 60,
  parameter int ORIGIN_Y = 20,
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [COL_W-1:0]    req_col,
  input  logic [ROW_W-1:0]    req_row,
  input  logic [COLOUR_W-1:0] req_colour,
  input  logic                req_border_en,
  input  logic [COLOUR_W-1:0] border_colour,
`ifdef CELL_PLOTTER_CLEAR_EN
  input  logic                clear_req,
  input  logic [COLOUR_W-1:0] clear_colour,
`endif
  output logic [X_W-1:0]      x,
  output logic [Y_W-1:0]      y,
  output logic [COLOUR_W-1:0] colour,
  output logic                write_en,
  output logic                busy,
  output logic                done
);

  localparam int IW  = (CELL_W > 1) ? $clog2(CELL_W) : 1;
  localparam int JW  = (CELL_H > 1) ? $clog2(CELL_H) : 1;
  localparam int PXW = X_W + COL_W + 2;
  localparam int PYW = Y_W + ROW_W + 2;

  typedef enum logic [1:0] {IDLE = 2'd0, DRAW = 2'd1, DONE = 2'd2} state_t;

  state_t                state_q, state_d;
  logic [IW-1:0]         i_q, i_d;
  logic [JW-1:0]         j_q, j_d;
  logic [COL_W-1:0]      col_q, col_d;
  logic [ROW_W-1:0]      row_q, row_d;
  logic [COLOUR_W-1:0]   fill_q, fill_d;
  logic [COLOUR_W-1:0]   bcol_q, bcol_d;
  logic                  ben_q, ben_d;
  logic [X_W-1:0]        x_q, x_d;
  logic [Y_W-1:0]        y_q, y_d;
  logic [COLOUR_W-1:0]   colour_q, colour_d;
  logic                  wr_q, wr_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [PXW-1:0]        px;
  logic [PYW-1:0]        py;
  logic                  edge_pix;
`ifdef CELL_PLOTTER_CLEAR_EN
  logic                  clr_q, clr_d;
  logic [X_W-1:0]        cx_q, cx_d;
  logic [Y_W-1:0]        cy_q, cy_d;
  logic [COLOUR_W-1:0]   ccol_q, ccol_d;
`endif

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    col_d   = col_q;
    row_d   = row_q;
    fill_d  = fill_q;
    bcol_d  = bcol_q;
    ben_d   = ben_q;
`ifdef CELL_PLOTTER_CLEAR_EN
    clr_d   = clr_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    ccol_d  = ccol_q;
`endif
    case (state_q)
      IDLE: begin
`ifdef CELL_PLOTTER_CLEAR_EN
        if (clear_req) begin
          state_d = DRAW;
          clr_d   = 1'b1;
          cx_d    = '0;
          cy_d    = '0;
          ccol_d  = clear_colour;
        end else
`endif
        if (req_valid) begin
          state_d = DRAW;
          i_d     = '0;
          j_d     = '0;
          col_d   = req_col;
          row_d   = req_row;
          fill_d  = req_colour;
          bcol_d  = border_colour;
          ben_d   = req_border_en;
        end
      end
      DRAW: begin
`ifdef CELL_PLOTTER_CLEAR_EN
        if (clr_q) begin
          if (cx_q == X_W'(SCREEN_W - 1)) begin
            cx_d = '0;
            if (cy_q == Y_W'(SCREEN_H - 1)) state_d = DONE;
            else cy_d = cy_q + Y_W'(1);
          end else begin
            cx_d = cx_q + X_W'(1);
          end
        end else
`endif
        begin
          if (i_q == IW'(CELL_W - 1)) begin
            i_d = '0;
            if (j_q == JW'(CELL_H - 1)) state_d = DONE;
            else j_d = j_q + JW'(1);
          end else begin
            i_d = i_q + IW'(1);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
`ifdef CELL_PLOTTER_CLEAR_EN
        clr_d   = 1'b0;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from next-state values so each pixel appears during its DRAW cycle.
  assign px = PXW'(ORIGIN_X) + PXW'(col_d) * PXW'(CELL_W) + PXW'(i_d);
  assign py = PYW'(ORIGIN_Y) + PYW'(row_d) * PYW'(CELL_H) + PYW'(j_d);
  assign edge_pix = (i_d == '0) || (i_d == IW'(CELL_W - 1)) ||
                    (j_d == '0) || (j_d == JW'(CELL_H - 1));

  always_comb begin
    wr_d     = 1'b0;
    x_d      = x_q;
    y_d      = y_q;
    colour_d = colour_q;
    busy_d   = (state_d != IDLE);
    done_d   = (state_d == DONE);
    if (state_d == DRAW) begin
`ifdef CELL_PLOTTER_CLEAR_EN
      if (clr_d) begin
        wr_d     = 1'b1;
        x_d      = cx_d;
        y_d      = cy_d;
        colour_d = ccol_d;
      end else
`endif
      if ((px < PXW'(SCREEN_W)) && (py < PYW'(SCREEN_H))) begin
        wr_d     = 1'b1;
        x_d      = px[X_W-1:0];
        y_d      = py[Y_W-1:0];
        colour_d = (ben_d && edge_pix) ? bcol_d : fill_d;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      i_q      <= '0;
      j_q      <= '0;
      col_q    <= '0;
      row_q    <= '0;
      fill_q   <= '0;
      bcol_q   <= '0;
      ben_q    <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      colour_q <= '0;
      wr_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef CELL_PLOTTER_CLEAR_EN
      clr_q    <= 1'b0;
      cx_q     <= '0;
      cy_q     <= '0;
      ccol_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      i_q      <= i_d;
      j_q      <= j_d;
      col_q    <= col_d;
      row_q    <= row_d;
      fill_q   <= fill_d;
      bcol_q   <= bcol_d;
      ben_q    <= ben_d;
      x_q      <= x_d;
      y_q      <= y_d;
      colour_q <= colour_d;
      wr_q     <= wr_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef CELL_PLOTTER_CLEAR_EN
      clr_q    <= clr_d;
      cx_q     <= cx_d;
      cy_q     <= cy_d;
      ccol_q   <= ccol_d;
`endif
    end
  end

  assign req_ready = (state_q == IDLE);
  assign x         = x_q;
  assign y         = y_q;
  assign colour    = colour_q;
  assign write_en  = wr_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_cell_plotter.sv
// Directed bench for cell_plotter; the screen-clear test runs only when
// CELL_PLOTTER_CLEAR_EN is defined.
module tb_cell_plotter;

  localparam int CW = 4;
  localparam int CH = 4;
  localparam int OX = 60;
  localparam int OY = 20;

  logic       clk;
  logic       reset_n;
  logic       req_valid;
  logic       req_ready;
  logic [3:0] req_col;
  logic [4:0] req_row;
  logic [5:0] req_colour;
  logic       req_border_en;
  logic [5:0] border_colour;
`ifdef CELL_PLOTTER_CLEAR_EN
  logic       clear_req;
  logic [5:0] clear_colour;
`endif
  logic [7:0] x;
  logic [6:0] y;
  logic [5:0] colour;
  logic       write_en;
  logic       busy;
  logic       done;

  int n_checks = 0;
  int n_errors = 0;
  int last_x = 0;
  int last_y = 0;
  int last_c = 0;

  cell_plotter dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_col       (req_col),
    .req_row       (req_row),
    .req_colour    (req_colour),
    .req_border_en (req_border_en),
    .border_colour (border_colour),
`ifdef CELL_PLOTTER_CLEAR_EN
    .clear_req     (clear_req),
    .clear_colour  (clear_colour),
`endif
    .x             (x),
    .y             (y),
    .colour        (colour),
    .write_en      (write_en),
    .busy          (busy),
    .done          (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Presents a request and returns right at the accepting clock edge.
  task automatic start_req(input int col, input int row, input int fill, input int ben,
                           input int bcol);
    int n = 0;
    @(negedge clk);
    req_col       = 4'(col);
    req_row       = 5'(row);
    req_colour    = 6'(fill);
    req_border_en = ben[0];
    border_colour = 6'(bcol);
    req_valid     = 1'b1;
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("ready_wait", req_ready, 1);
    @(posedge clk);
  endtask

  // Checks cycles 1..16 of a sweep, then the done cycle and the ready cycle.
  task automatic sweep_check(input int col, input int row, input int fill, input int ben,
                             input int bcol, input bit keep, input int abort_after,
                             input int new_col, input int fx, input int fy);
    int k = 0;
    for (int j = 0; j < CH; j++) begin
      for (int i = 0; i < CW; i++) begin
        int px, py, ew;
        k++;
        @(negedge clk);
        if (k == 1 && !keep) req_valid = 1'b0;
        if (k == 4 && new_col >= 0) req_col = 4'(new_col);
        px = OX + col * CW + i;
        py = OY + row * CH + j;
        if (px < 160 && py < 120) begin
          ew = 1;
          last_x = px;
          last_y = py;
          last_c = (ben != 0 && (i == 0 || i == CW-1 || j == 0 || j == CH-1)) ? bcol : fill;
        end else begin
          ew = 0;
        end
        if (k == 1 && fx >= 0) begin
          check("first_x", x, fx);
          check("first_y", y, fy);
        end
        check("write_en", write_en, ew);
        check("x", x, last_x);
        check("y", y, last_y);
        check("colour", colour, last_c);
        check("busy_draw", busy, 1);
        check("ready_draw", req_ready, 0);
        if (k == abort_after) return;
      end
    end
    @(negedge clk);
    check("done_pulse", done, 1);
    check("ready_done", req_ready, 0);
    check("wr_done", write_en, 0);
    check("busy_done", busy, 1);
    @(negedge clk);
    check("done_clear", done, 0);
    check("ready_back", req_ready, 1);
    check("busy_idle", busy, 0);
  endtask

  initial begin
    reset_n       = 1'b0;
    req_valid     = 1'b0;
    req_col       = '0;
    req_row       = '0;
    req_colour    = '0;
    req_border_en = 1'b0;
    border_colour = '0;
`ifdef CELL_PLOTTER_CLEAR_EN
    clear_req     = 1'b0;
    clear_colour  = '0;
`endif
    repeat (2) @(negedge clk);
    check("rst_wr", write_en, 0);
    check("rst_x", x, 0);
    check("rst_y", y, 0);
    check("rst_colour", colour, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ready", req_ready, 1);
    reset_n = 1'b1;

    // 1: plain fill, first (68,32), last (71,35)
    start_req(2, 3, 'h30, 0, 0);
    sweep_check(2, 3, 'h30, 0, 0, 1'b0, 0, -1, 68, 32);
    check("t1_last_x", x, 71);
    check("t1_last_y", y, 35);

    // 2: border on, inner 2x2 keeps the fill colour
    start_req(2, 3, 'h30, 1, 'h3F);
    sweep_check(2, 3, 'h30, 1, 'h3F, 1'b0, 0, -1, 68, 32);

    // 3: row 31 is below the screen; outputs must hold (71,35,3F)
    start_req(2, 31, 'h30, 0, 0);
    sweep_check(2, 31, 'h30, 0, 0, 1'b0, 0, -1, -1, -1);
    check("t3_hold_x", x, 71);
    check("t3_hold_c", colour, 'h3F);

    // 4: req_valid held; col changes mid-sweep; second accept at cycle 18
    start_req(2, 3, 'h0C, 0, 0);
    sweep_check(2, 3, 'h0C, 0, 0, 1'b1, 0, 5, 68, 32);
    sweep_check(5, 3, 'h0C, 0, 0, 1'b0, 0, -1, 80, 32);

    // 5: reset after the 5th pixel
    start_req(1, 2, 'h15, 1, 'h2A);
    sweep_check(1, 2, 'h15, 1, 'h2A, 1'b0, 5, -1, 64, 28);
    check("t5_pre_wr", write_en, 1);
    reset_n = 1'b0;
    #1;
    check("t5_rst_wr", write_en, 0);
    check("t5_rst_busy", busy, 0);
    check("t5_rst_done", done, 0);
    last_x = 0;
    last_y = 0;
    last_c = 0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("t5_ready", req_ready, 1);
    check("t5_no_done", done, 0);
    start_req(1, 2, 'h15, 1, 'h2A);
    sweep_check(1, 2, 'h15, 1, 'h2A, 1'b0, 0, -1, 64, 28);

`ifdef CELL_PLOTTER_CLEAR_EN
    // 6: clear wins over a simultaneous cell request
    begin
      int bad = 0;
      @(negedge clk);
      req_col       = 4'd2;
      req_row       = 5'd3;
      req_colour    = 6'h30;
      req_border_en = 1'b0;
      clear_colour  = 6'h00;
      clear_req     = 1'b1;
      req_valid     = 1'b1;
      @(posedge clk);
      for (int k = 0; k < 160 * 120; k++) begin
        @(negedge clk);
        if (k == 0) begin
          clear_req = 1'b0;
          check("clr_first_x", x, 0);
          check("clr_first_y", y, 0);
          check("clr_first_wr", write_en, 1);
        end
        if (k == 160 * 120 - 1) begin
          check("clr_last_x", x, 159);
          check("clr_last_y", y, 119);
        end
        if (write_en !== 1'b1 || x !== 8'(k % 160) || y !== 7'(k / 160) ||
            colour !== 6'h00 || busy !== 1'b1 || req_ready !== 1'b0)
          bad++;
      end
      check("clr_sweep_bad", bad, 0);
      @(negedge clk);
      check("clr_done", done, 1);
      check("clr_ready_done", req_ready, 0);
      check("clr_wr_done", write_en, 0);
      @(negedge clk);
      check("clr_ready_back", req_ready, 1);
      last_x = 159;
      last_y = 119;
      last_c = 0;
      sweep_check(2, 3, 'h30, 0, 0, 1'b0, 0, -1, 68, 32);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
